// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the fetch and decode_pipe stages.
// It resolves three hazards:
//   - load-use: one bubble is inserted into ID/EX.
//   - multi-cycle MUL/DIV in EX: the front end is frozen until the result is ready.
//   - taken branch/jump resolved in EX: the younger instructions are flushed.
// It also keeps saturating stall and flush cycle counters.
// The stall/flush outputs are combinational from the registered state and the current inputs.
module hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core_N,
  input  logic [4:0]           id_rs1_di,
  input  logic [4:0]           id_rs2_di,
  input  logic                 id_rs1_used_di,
  input  logic                 id_rs2_used_di,
  input  logic [4:0]           ex_rd_di,
  input  logic                 ex_load_di,
  input  logic                 ex_mul_valid_di,
  input  logic                 ex_branch_taken_di,
  output logic                 stall_fetch_do,
  output logic                 flush_fetch_do,
  output logic                 stall_decode_do,
  output logic                 flush_decode_do,
  output logic                 mul_busy_do,
  output logic [CNT_WIDTH-1:0] stall_count_do,
  output logic [CNT_WIDTH-1:0] flush_count_do
);

  // The wait counter must be at least one bit wide, even when no MUL wait is possible.
  localparam int CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  // The detection cycle plus the cnt!=0 cycles give MUL_LATENCY-1 stall cycles in total.
  localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  logic                 mul_det;
  logic                 load_use;

  // MUL detection exists only when the multiplier takes more than one cycle.
  generate
    if (MUL_LATENCY > 1) begin : g_mul
      assign mul_det = ex_mul_valid_di;
    end else begin : g_no_mul
      assign mul_det = ex_mul_valid_di & 1'b0;
    end
  endgenerate

  // A load whose destination is read by the instruction now in decode.
  // x0 is never a real dependency.
  assign load_use = ex_load_di && (ex_rd_di != 5'd0) &&
                    ((id_rs1_used_di && (id_rs1_di == ex_rd_di)) ||
                     (id_rs2_used_di && (id_rs2_di == ex_rd_di)));

  // State register: FSM state and the MUL wait down-counter.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  // A branch in IDLE wins over a MUL; in MUL_WAIT the inputs are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!ex_branch_taken_di && mul_det) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic.
  // The outputs are forced low while reset is asserted.
  // A load-use bubbles ID/EX (flush) rather than holding it, so stall_decode
  // and flush_decode are never driven high together.
  always_comb begin
    stall_fetch_do  = 1'b0;
    flush_fetch_do  = 1'b0;
    stall_decode_do = 1'b0;
    flush_decode_do = 1'b0;
    mul_busy_do     = 1'b0;
    if (Rst_Core_N) begin
      case (state_q)
        IDLE: begin
          if (ex_branch_taken_di) begin
            flush_fetch_do  = 1'b1;
            flush_decode_do = 1'b1;
          end else if (mul_det) begin
            stall_fetch_do  = 1'b1;
            stall_decode_do = 1'b1;
          end else if (load_use) begin
            stall_fetch_do  = 1'b1;
            flush_decode_do = 1'b1;
          end
        end
        MUL_WAIT: begin
          mul_busy_do = 1'b1;
          if (cnt_q != '0) begin
            stall_fetch_do  = 1'b1;
            stall_decode_do = 1'b1;
          end
        end
        default: begin
          mul_busy_do = 1'b0;
        end
      endcase
    end
  end

  // Performance counters.
  // Each counter advances on every edge where its output is high and sticks at all-ones.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fetch_do && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (flush_fetch_do && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_count_do = stall_cnt_q;
  assign flush_count_do = flush_cnt_q;

endmodule
